// File: rtl/mem_lane_array.sv
// rtl/mem_lane_array.sv - lane-sliced simple dual-port word memory with init sweep
//
// Purpose: one write port and one registered read port over DEPTH = 2**ADDR_W
// words of NUM_LANES lanes x LANE_W bits. After reset, or on a clr pulse, a
// hardware sweep writes INIT_VAL into every lane of every word; all accesses
// are refused while the sweep runs.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   clr                 single-cycle request to re-run the init sweep
//   init_busy           high while the sweep runs
//   wr_en/wr_addr/wr_be/wr_data/wr_ready   write port with per-lane enables
//   rd_en/rd_addr/rd_ready                 read request
//   rd_valid/rd_data                       one-cycle strobe, registered data
//
// Build option: define MEM_LANE_WR_FWD_EN for write-first behaviour on a
// same-cycle read and write to one address; default is read-first.

module mem_lane_array #(
    parameter int                ADDR_W    = 6,
    parameter int                NUM_LANES = 4,
    parameter int                LANE_W    = 8,
    parameter logic [LANE_W-1:0] INIT_VAL  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    output logic                          init_busy,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [NUM_LANES-1:0]          wr_be,
    input  logic [NUM_LANES*LANE_W-1:0]   wr_data,
    output logic                          wr_ready,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_ready,
    output logic                          rd_valid,
    output logic [NUM_LANES*LANE_W-1:0]   rd_data
);

    localparam int W     = NUM_LANES * LANE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_busy_q, init_busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic [W-1:0]        rd_data_q, rd_data_d;

    // Storage is deliberately not reset; the sweep initialises it.
    logic [W-1:0]        mem [DEPTH];

    logic                wr_fire;
    logic                rd_fire;
    logic [W-1:0]        rd_word;

    assign wr_fire = wr_en && !init_busy_q;
    assign rd_fire = rd_en && !init_busy_q;

    // Word presented to the read register this cycle.
    always_comb begin
        rd_word = mem[rd_addr];
`ifdef MEM_LANE_WR_FWD_EN
        // Write-first: lanes being written this cycle bypass the array.
        if (wr_fire && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        rd_valid_d  = rd_fire;
        rd_data_d   = rd_fire ? rd_word : rd_data_q;

        case (state_q)
            S_INIT: begin
                if (clr) begin
                    // Restart the sweep from the first word.
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d     = S_RUN;
                        init_busy_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_d     = S_INIT;
                    cnt_d       = '0;
                    init_busy_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_INIT;
                cnt_d       = '0;
                init_busy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Array write port: the sweep owns it while in INIT, the user otherwise.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[cnt_q] <= {NUM_LANES{INIT_VAL}};
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign init_busy = init_busy_q;
    assign wr_ready  = !init_busy_q;
    assign rd_ready  = !init_busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_lane_array.sv
// tb/tb_mem_lane_array.sv - scoreboard bench for mem_lane_array
module tb_mem_lane_array;

    localparam int DEPTH   = 64;
    localparam int S_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        clr, wr_en, rd_en;
    logic [5:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        init_busy, wr_ready, rd_ready, rd_valid;
    logic [31:0] rd_data;

    logic        s_clr, s_wr_en, s_rd_en;
    logic [2:0]  s_wr_addr, s_rd_addr;
    logic [3:0]  s_wr_be;
    logic [31:0] s_wr_data;
    logic        s_init_busy, s_wr_ready, s_rd_ready, s_rd_valid;
    logic [31:0] s_rd_data;

    mem_lane_array dut (
        .clk(clk), .rst(rst), .clr(clr), .init_busy(init_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    mem_lane_array #(.ADDR_W(3), .INIT_VAL(8'h5A)) dut_s (
        .clk(clk), .rst(rst), .clr(s_clr), .init_busy(s_init_busy),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_be(s_wr_be), .wr_data(s_wr_data),
        .wr_ready(s_wr_ready), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_ready(s_rd_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          busy_left;
    int          s_left;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    int          cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic fill_model();
        for (int a = 0; a < DEPTH; a++) model[a] = 32'h0;
    endtask

    // Scoreboard consumer: each expected read must appear exactly at its cycle.
    always @(negedge clk) begin
        if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
            check("rd_valid", {31'b0, rd_valid}, 32'h1);
            check("rd_data", rd_data, exp_q[0]);
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
        end else if (rd_valid) begin
            check("spurious_rd_valid", {31'b0, rd_valid}, 32'h0);
        end
    end

    // One clock of stimulus; entered and left at posedge + 1.
    task automatic step(input logic we, input logic [5:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic re, input logic [5:0] ra,
                        input logic c);
        logic        mbusy;
        logic [31:0] rw;
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra; clr = c;
        mbusy = (busy_left != 0);
        check("init_busy", {31'b0, init_busy}, {31'b0, mbusy});
        check("wr_ready", {31'b0, wr_ready}, {31'b0, !mbusy});
        check("rd_ready", {31'b0, rd_ready}, {31'b0, !mbusy});
        check("s_init_busy", {31'b0, s_init_busy}, {31'b0, (s_left != 0)});
        if (re && !mbusy) begin
            rw = model[ra];
`ifdef MEM_LANE_WR_FWD_EN
            if (we && wa == ra) rw = merge(rw, wd, be);
`endif
            exp_q.push_back(rw);
            cyc_q.push_back(cyc + 1);
        end
        if (we && !mbusy) model[wa] = merge(model[wa], wd, be);
        @(posedge clk);
        if (c) begin
            busy_left = DEPTH;
            fill_model();
        end else if (busy_left > 0) begin
            busy_left--;
        end
        if (s_left > 0) s_left--;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        #1;
        check("rst_init_busy", {31'b0, init_busy}, 32'h1);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_left = DEPTH;
        s_left    = S_DEPTH;
        fill_model();
    endtask

    initial begin
        clr = 0; wr_en = 0; rd_en = 0; wr_addr = 0; rd_addr = 0; wr_be = 0; wr_data = 0;
        s_clr = 0; s_wr_en = 0; s_wr_addr = 0; s_wr_be = 0; s_wr_data = 0;
        s_rd_en = 1; s_rd_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_init_busy", {31'b0, init_busy}, 32'h1);
        check("reset_rd_ready", {31'b0, rd_ready}, 32'h0);
        check("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("reset_rd_data", rd_data, 32'h0);
        rst = 1'b0;
        busy_left = DEPTH;
        s_left    = S_DEPTH;
        fill_model();

        // Sweep with a read held on address 0 the whole time.
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd0, 1'b0);
        idle(1);

        // Partial-lane writes.
        step(1'b1, 6'd5, 4'b1111, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0);
        step(1'b1, 6'd5, 4'b0101, 32'h11223344, 1'b0, 6'd0, 1'b0);
        step(1'b1, 6'd5, 4'b0000, 32'hFFFFFFFF, 1'b1, 6'd5, 1'b0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5, 1'b0);
        idle(2);
        check("model_addr5", model[5], 32'hDE22BE44);

        // Top address and back-to-back reads.
        step(1'b1, 6'd63, 4'b1111, 32'hA5A5A5A5, 1'b0, 6'd0, 1'b0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd0, 1'b0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd63, 1'b0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd0, 1'b0);
        idle(2);

        // Same-address collision, full and partial lanes; other-address independence.
        step(1'b1, 6'd9, 4'b1111, 32'h01020304, 1'b0, 6'd0, 1'b0);
        step(1'b1, 6'd9, 4'b1111, 32'hCAFEF00D, 1'b1, 6'd9, 1'b0);
        step(1'b1, 6'd9, 4'b0011, 32'h5555AAAA, 1'b1, 6'd9, 1'b0);
        step(1'b1, 6'd10, 4'b1111, 32'h77777777, 1'b1, 6'd9, 1'b0);
        step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd10, 1'b0);
        idle(1);

        // clr with a same-cycle write and read, then refused traffic during the sweep.
        while (cyc < 100) idle(1);
        step(1'b1, 6'd12, 4'b1111, 32'h12345678, 1'b1, 6'd9, 1'b1);
        for (int i = 0; i < 19; i++)
            step(1'b1, 6'(i), 4'b1111, 32'hFFFF0000, 1'b1, 6'(i), 1'b0);
        pulse_rst();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 6'(i), 4'b1111, 32'h0BADF00D, 1'b1, 6'(i), 1'b0);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'(a), 1'b0);
        idle(2);

        // Small instance: every word holds the replicated INIT_VAL.
        for (int a = 0; a < S_DEPTH; a++) begin
            s_rd_addr = 3'(a);
            @(posedge clk);
            @(negedge clk);
            check("s_rd_valid", {31'b0, s_rd_valid}, 32'h1);
            check("s_rd_data", s_rd_data, 32'h5A5A5A5A);
        end
        @(posedge clk);
        #1;
        idle(2);

        check("sb_drain", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
